// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main_memory between the CPU datapath (port 0) and a
// secondary requester (port 1). Round-robin arbitration with zero-cycle grant,
// optional lock for read-modify-write sequences with a bounded hold time, and
// registered read return one cycle after the grant.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              lock_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKED0 = 2'd1,
    LOCKED1 = 2'd2
  } state_t;

  localparam logic [7:0] MaxLock = 8'(MAX_LOCK);

  state_t            st_q, st_d;
  logic              lastGnt_q, lastGnt_d;
  logic [7:0]        lockCnt_q, lockCnt_d;
  logic              lockErr_q, lockErr_d;
  logic              rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              grant0, grant1;

  // Arbitration and lock bookkeeping: decides this cycle's grant and the next
  // owner state. A holder that has used up its lock budget is not granted in
  // the release cycle, so it never exceeds MAX_LOCK consecutive grants.
  always_comb begin
    st_d      = st_q;
    lastGnt_d = lastGnt_q;
    lockCnt_d = lockCnt_q;
    lockErr_d = 1'b0;
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!rst) begin
      case (st_q)
        IDLE: begin
          if (req0 && req1) begin
            grant0 = lastGnt_q;
            grant1 = ~lastGnt_q;
          end else begin
            grant0 = req0;
            grant1 = req1;
          end
          if (grant0 && lock0) begin
            st_d      = LOCKED0;
            lockCnt_d = 8'd1;
          end else if (grant1 && lock1) begin
            st_d      = LOCKED1;
            lockCnt_d = 8'd1;
          end
        end
        LOCKED0: begin
          if (lock0 && (lockCnt_q >= MaxLock)) begin
            st_d      = IDLE;
            lockCnt_d = 8'd0;
            lockErr_d = 1'b1;
            lastGnt_d = 1'b0;
          end else begin
            grant0 = req0;
            if (!lock0) begin
              st_d      = IDLE;
              lockCnt_d = 8'd0;
            end else begin
              lockCnt_d = lockCnt_q + 8'd1;
            end
          end
        end
        LOCKED1: begin
          if (lock1 && (lockCnt_q >= MaxLock)) begin
            st_d      = IDLE;
            lockCnt_d = 8'd0;
            lockErr_d = 1'b1;
            lastGnt_d = 1'b1;
          end else begin
            grant1 = req1;
            if (!lock1) begin
              st_d      = IDLE;
              lockCnt_d = 8'd0;
            end else begin
              lockCnt_d = lockCnt_q + 8'd1;
            end
          end
        end
        default: begin
          st_d      = IDLE;
          lockCnt_d = 8'd0;
        end
      endcase
      if (grant0) begin
        lastGnt_d = 1'b0;
      end else if (grant1) begin
        lastGnt_d = 1'b1;
      end
    end
  end

  // Memory-side mux: the granted port drives both address buses; idle drives 0.
  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (grant0) begin
      mem_raddr = addr0;
      mem_waddr = addr0;
      mem_wdata = wdata0;
      mem_wen   = we0;
    end else if (grant1) begin
      mem_raddr = addr1;
      mem_waddr = addr1;
      mem_wdata = wdata1;
      mem_wen   = we1;
    end
  end

  // State, fairness pointer, lock counter and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= IDLE;
      lastGnt_q <= 1'b1;
      lockCnt_q <= 8'd0;
      lockErr_q <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      st_q      <= st_d;
      lastGnt_q <= lastGnt_d;
      lockCnt_q <= lockCnt_d;
      lockErr_q <= lockErr_d;
      rvalid0_q <= grant0 & ~we0;
      rvalid1_q <= grant1 & ~we1;
      if (grant0 && !we0) begin
        rdata0_q <= mem_rdata;
      end
      if (grant1 && !we1) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  assign gnt0     = grant0;
  assign gnt1     = grant1;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign lock_err = lockErr_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single `main_memory` instance between the CPU datapath (port 0, driven by `main_memory_control`) and a secondary requester (port 1: program loader / debug access). It grants at most one access per cycle with round-robin fairness. It supports a lock, so one port can perform an uninterrupted read-modify-write sequence, and enforces a lock timeout. Read data is returned one cycle after grant, with a valid strobe.

## Interface
- `ADDR_W`, default 32: address width of both ports and memory side.
- `DATA_W`, default 32: data width.
- `MAX_LOCK`, default 16: maximum consecutive cycles one port may hold a lock; range 1..255.

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `req0`, `req1`  input  1  access request per port.
- `we0`, `we1`  input  1  1 = write, 0 = read; valid while `reqN`.
- `lock0`, `lock1`  input  1  request to keep ownership after this access.
- `addr0`, `addr1`  input  ADDR_W  access address.
- `wdata0`, `wdata1`  input  DATA_W  write data.
- `gnt0`, `gnt1`  output  1  combinational grant; access is performed this cycle.
- `rvalid0`, `rvalid1`  output  1  registered; read data for port N is valid this cycle.
- `rdata0`, `rdata1`  output  DATA_W  registered read data.
- `lock_err`  output  1  registered one-cycle pulse when a lock is force-released.
- `mem_raddr`  output  ADDR_W  to `main_memory.read_address`.
- `mem_waddr`  output  ADDR_W  to `main_memory.write_address`.
- `mem_wdata`  output  DATA_W  to `main_memory.write_data`.
- `mem_wen`  output  1  to `main_memory.write_enable`.
- `mem_rdata`  input  DATA_W  from `main_memory.read_data` (combinational read).

## Operation
- State `st`: IDLE, LOCKED0, LOCKED1. Registers: `last_gnt` (port most recently granted), `lock_cnt` (8 bits), and the read-return registers.

Grant rules (combinational from state and requests):
- IDLE, one port requesting: that port is granted.
- IDLE, both ports requesting: the port ≠ `last_gnt` is granted.
- LOCKEDn: only port n may be granted, when `reqn`=1. The other port's `gnt` stays 0 regardless of its request.
- During `rst`: both grants are 0.

Memory drive:
- The granted port's `addr` goes to both `mem_raddr` and `mem_waddr`.
- `mem_wdata` = granted port's `wdata`.
- `mem_wen` = granted & `we`.
- With no grant: all memory outputs are 0.

Read return:
- On a granted read, `rdataN` <= `mem_rdata` and `rvalidN` <= 1 at the next edge.
- `rvalidN` <= 0 otherwise.
- `rdataN` holds its value when not updated.

State transitions:
- IDLE -> LOCKEDn: on a grant to n with `lockn`=1. Set `lock_cnt`=1.
- LOCKEDn -> IDLE: on an edge where `lockn`=0. An access in that cycle is still granted.
- LOCKEDn, `lockn`=1, `lock_cnt` < MAX_LOCK: increment `lock_cnt` every cycle, whether or not `reqn` is high.
- LOCKEDn, `lockn`=1, `lock_cnt` == MAX_LOCK: go to IDLE, pulse `lock_err`, set `last_gnt`=n so the other port wins the next contention.
- A lock request in the first cycle after a forced release is honoured normally.

`last_gnt` updates to the granted port on every granted cycle.

Reset values:
- `st`=IDLE, `last_gnt`=1 (port 0 wins the first contention), `lock_cnt`=0.
- `rvalid0/1`=0, `rdata0/1`=0, `lock_err`=0.
- Combinational outputs are 0 while `rst`=1.

Reset mid-lock or mid-read: the state is dropped. The pending `rvalid` is not asserted after reset.

## Timing
- Grant latency: 0 cycles. `gnt` is asserted in the same cycle as `req` when arbitration is won.
- The requester must hold `req`/`addr`/`we`/`wdata` until it sees `gnt`=1.
- Write commits at the rising edge that ends the grant cycle.
- Read latency: 1 cycle (`rvalid` at grant+1). Throughput is one access per cycle total.
- Back-to-back ordering: a read granted the cycle after a write to the same address returns the new data.
- Lock ownership: in continuous contention with `lock0` held, port 0 gets grants for at most MAX_LOCK consecutive cycles. Then `lock_err`=1 for one cycle and port 1 is granted.
- No combinational path from `mem_rdata` to any output except through registers.

## Test plan
- Single read: memory[0x10]=0xDEADBEEF; `req0`=1, `we0`=0, `addr0`=0x10 for one cycle. Expect `gnt0`=1 that cycle, then `rvalid0`=1 and `rdata0`=0xDEADBEEF next cycle, and `gnt1`=0 throughout.
- Contention: after reset, both ports request reads every cycle for 4 cycles. Expect grants 0,1,0,1 and `rvalid` pulses following each grant by one cycle.
- Write then read: port 1 writes 0x5 to 0x20 in cycle t, then reads 0x20 in cycle t+1. Expect `mem_wen`=1 only in t, and `rdata1`=0x5 with `rvalid1`=1 at t+2.
- Lock: port 0 holds `lock0`=1 for 3 accesses while `req1` is high. Expect `gnt1`=0 for those cycles. `lock0`=0 on the 4th access, and port 1 is granted the cycle after.
- Lock timeout: MAX_LOCK=4, `lock0` stuck at 1, both requesting. Expect 4 consecutive `gnt0`, then `lock_err`=1 for one cycle and `gnt1`=1.
- Reset mid-lock: assert `rst` while in LOCKED1 with a read granted. Expect `rvalid1`=0, `gnt`=0 during reset, and port 0 winning the first contention afterwards.
